rsv_valve_scheduler: RTL

Shared-supply scheduler for a bank of reservoirs. Each reservoir is served by the same valve scheme: nominal valves fr1/fr2/fr3 plus a supplemental valve dfr. The block sits above the per-reservoir level logic. Once per fixed-length epoch it samples every reservoir's level sensors and computes each valve demand. It then grants valves from a finite supply capacity using a rotating-priority sequential walk, and holds those grants constant for the rest of the epoch.

---
 rtl/rsv_valve_scheduler_if.sv | 25 ++
 rtl/rsv_valve_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rsv_valve_scheduler_if.sv
// rtl/rsv_valve_scheduler_if.sv - sensor/grant bundle between reservoir bank and valve scheduler
//
// Ports (signals):
//   s      [3*NRES]  level sensors, reservoir i on s[3i+2:3i] = {s3,s2,s1}
//   fr     [3*NRES]  granted nominal valves, reservoir i on fr[3i+2:3i] = {fr3,fr2,fr1}
//   dfr    [NRES]    granted supplemental valves
//   used   [UW]      units granted for the current epoch
//   starve [NRES]    reservoir under-served for STARVE_LIM consecutive epochs
//   fault  [NRES]    sticky sensor-pattern fault
// Modports: master = scheduler side, slave = reservoir bank side.
interface rsv_valve_scheduler_if #(
    parameter int NRES = 4
);
    localparam int UW = $clog2(4*NRES+1);

    logic [3*NRES-1:0] s;
    logic [3*NRES-1:0] fr;
    logic [NRES-1:0]   dfr;
    logic [UW-1:0]     used;
    logic [NRES-1:0]   starve;
    logic [NRES-1:0]   fault;

    modport master (input s, output fr, output dfr, output used, output starve, output fault);
    modport slave  (output s, input fr, input dfr, input used, input starve, input fault);
endinterface

// File: rtl/rsv_valve_scheduler.sv
// rtl/rsv_valve_scheduler.sv - epoch-based rotating-priority valve grant scheduler
//
// Once per EPOCH cycles the block samples all reservoir sensors, walks the
// reservoirs one per cycle starting at a rotating pointer, grants valve units
// out of a CAP-unit supply, and publishes the grants for the rest of the epoch.
//
// Ports:
//   clk     clock, rising edge
//   reset   synchronous, active-high
//   bus_if  rsv_valve_scheduler_if.master: s in; fr, dfr, used, starve, fault out
//
// Optional feature macro: RSV_SCHED_FAULT_EN (sticky non-thermometer sensor fault;
// a faulted reservoir demands nothing and keeps its level history frozen).
module rsv_valve_scheduler #(
    parameter int NRES       = 4,
    parameter int CAP        = 6,
    parameter int EPOCH      = 16,
    parameter int STARVE_LIM = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    rsv_valve_scheduler_if.master bus_if
);
    localparam int UW = $clog2(4*NRES+1);
    localparam int IW = (NRES > 1) ? $clog2(NRES) : 1;
    localparam int CW = $clog2(EPOCH);

    typedef enum logic [1:0] {SAMPLE, ALLOC, COMMIT, WAIT} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     epoch_q, epoch_d;

    logic [IW-1:0]     ptr_q, walk_q;
    logic [UW-1:0]     rem_q;
    logic [1:0]        lvl_q  [NRES];
    logic [1:0]        prev_q [NRES];
    logic [3:0]        cnt_q  [NRES];
    logic [NRES-1:0]   dir_q, dreq_q, short_q;
    logic [3*NRES-1:0] sh_fr_q, fr_q;
    logic [NRES-1:0]   sh_dfr_q, dfr_q, starve_q;
    logic [UW-1:0]     used_q;
`ifdef RSV_SCHED_FAULT_EN
    logic [NRES-1:0]   fault_q, smp_bad;
`endif

    // ---------------- FSM: one epoch = SAMPLE, NRES x ALLOC, COMMIT, WAIT...
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SAMPLE;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            epoch_q <= epoch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        epoch_d = (epoch_q == CW'(EPOCH-1)) ? '0 : epoch_q + 1'b1;
        case (state_q)
            SAMPLE:  state_d = ALLOC;
            // ALLOC occupies epoch cycles 1..NRES
            ALLOC:   if (epoch_q == CW'(NRES)) state_d = COMMIT;
            COMMIT:  state_d = WAIT;
            WAIT:    if (epoch_q == CW'(EPOCH-1)) state_d = SAMPLE;
            default: state_d = SAMPLE;
        endcase
    end

    // ---------------- sample-cycle level decode and direction update
    logic [1:0]      smp_lvl [NRES];
    logic [NRES-1:0] smp_dir;

    always_comb begin
        for (int i = 0; i < NRES; i++) begin
            smp_lvl[i] = bus_if.s[3*i+2] ? 2'd3 :
                         bus_if.s[3*i+1] ? 2'd2 :
                         bus_if.s[3*i]   ? 2'd1 : 2'd0;
            smp_dir[i] = dir_q[i];
            if (smp_lvl[i] < prev_q[i])
                smp_dir[i] = 1'b1;
            else if (smp_lvl[i] > prev_q[i])
                smp_dir[i] = 1'b0;
        end
    end

`ifdef RSV_SCHED_FAULT_EN
    always_comb begin
        for (int i = 0; i < NRES; i++)
            smp_bad[i] = (bus_if.s[3*i+1] & ~bus_if.s[3*i]) | (bus_if.s[3*i+2] & ~bus_if.s[3*i+1]);
    end
`endif

    // ---------------- allocation step for the reservoir at walk_q
    logic [1:0]    a_nom;
    logic [UW-1:0] a_g, a_left;
    logic          a_gd, a_short;
    logic [2:0]    a_fr;
    logic [IW-1:0] walk_nxt;

    always_comb begin
        a_nom   = 2'd3 - lvl_q[walk_q];
        a_g     = (UW'(a_nom) < rem_q) ? UW'(a_nom) : rem_q;
        a_left  = rem_q - a_g;
        a_gd    = dreq_q[walk_q] & (a_left != '0);
        a_short = (a_g != UW'(a_nom)) | (dreq_q[walk_q] & ~a_gd);
        // nominal units fill fr1 first, then fr2, then fr3
        case (a_g)
            UW'(0):  a_fr = 3'b000;
            UW'(1):  a_fr = 3'b001;
            UW'(2):  a_fr = 3'b011;
            default: a_fr = 3'b111;
        endcase
        walk_nxt = (walk_q == IW'(NRES-1)) ? '0 : walk_q + 1'b1;
    end

    // ---------------- commit: next priority pointer and starvation counters
    logic [IW-1:0] ptr_nxt;
    logic [3:0]    cnt_nxt [NRES];
    int            j;

    always_comb begin
        ptr_nxt = (ptr_q == IW'(NRES-1)) ? '0 : ptr_q + 1'b1;
        j = 0;
        // scan walk order backwards so the earliest under-served reservoir wins
        for (int k = NRES-1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NRES) j = j - NRES;
            if (short_q[j]) ptr_nxt = IW'(j);
        end
        for (int i = 0; i < NRES; i++)
            cnt_nxt[i] = short_q[i] ? ((cnt_q[i] == 4'd15) ? 4'd15 : cnt_q[i] + 4'd1) : 4'd0;
    end

    // ---------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            walk_q   <= '0;
            rem_q    <= '0;
            dir_q    <= '0;
            dreq_q   <= '0;
            short_q  <= '0;
            sh_fr_q  <= '0;
            sh_dfr_q <= '0;
            fr_q     <= '0;
            dfr_q    <= '0;
            used_q   <= '0;
            starve_q <= '0;
            for (int i = 0; i < NRES; i++) begin
                lvl_q[i]  <= 2'd0;
                prev_q[i] <= 2'd0;
                cnt_q[i]  <= 4'd0;
            end
`ifdef RSV_SCHED_FAULT_EN
            fault_q  <= '0;
`endif
        end else begin
            case (state_q)
                SAMPLE: begin
                    rem_q  <= UW'(CAP);
                    walk_q <= ptr_q;
                    for (int i = 0; i < NRES; i++) begin
`ifdef RSV_SCHED_FAULT_EN
                        fault_q[i] <= fault_q[i] | smp_bad[i];
                        // level 3 with no dfr request means zero demand
                        if (fault_q[i] | smp_bad[i]) begin
                            lvl_q[i]  <= 2'd3;
                            dreq_q[i] <= 1'b0;
                        end else
`endif
                        begin
                            lvl_q[i]  <= smp_lvl[i];
                            prev_q[i] <= smp_lvl[i];
                            dir_q[i]  <= smp_dir[i];
                            dreq_q[i] <= (smp_lvl[i] == 2'd0) | (smp_dir[i] & (smp_lvl[i] != 2'd3));
                        end
                    end
                end
                ALLOC: begin
                    sh_fr_q[3*walk_q +: 3] <= a_fr;
                    sh_dfr_q[walk_q]       <= a_gd;
                    short_q[walk_q]        <= a_short;
                    rem_q                  <= a_left - UW'(a_gd);
                    walk_q                 <= walk_nxt;
                end
                COMMIT: begin
                    fr_q   <= sh_fr_q;
                    dfr_q  <= sh_dfr_q;
                    used_q <= UW'(CAP) - rem_q;
                    ptr_q  <= ptr_nxt;
                    for (int i = 0; i < NRES; i++) begin
                        cnt_q[i]    <= cnt_nxt[i];
                        starve_q[i] <= (cnt_nxt[i] >= 4'(STARVE_LIM));
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_if.fr     = fr_q;
    assign bus_if.dfr    = dfr_q;
    assign bus_if.used   = used_q;
    assign bus_if.starve = starve_q;
`ifdef RSV_SCHED_FAULT_EN
    assign bus_if.fault  = fault_q;
`else
    assign bus_if.fault  = '0;
`endif
endmodule
